cpu_seq_ctrl: RTL

Multi-cycle instruction sequencer for the 8-bit processor. It replaces single-cycle operation with a fetch/decode/execute/memory/writeback FSM. It also shares one 8-bit memory port between instruction fetch and load/store accesses. It sits between the shared memory and the datapath, and feeds the fetched instruction to the existing decode logic. It gates register and memory writes so each is issued exactly once per instruction.

---
 rtl/cpu_seq_ctrl.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer sharing one 8-bit memory port.
// Optional bus watchdog enabled by defining CPU_SEQ_WATCHDOG_EN.
module cpu_seq_ctrl #(
  parameter int unsigned         ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
  parameter int unsigned         WD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  input  logic [7:0]        alu_result,
  input  logic [7:0]        rs2_data,
  input  logic              branch_taken,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        load_data,
  output logic              reg_we,
  output logic              wb_sel,
  output logic              illegal,
  output logic              halted,
  output logic              bus_err,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetchHi = 3'd1,
    StFetchLo = 3'd2,
    StDecode  = 3'd3,
    StExec    = 3'd4,
    StMem     = 3'd5,
    StWb      = 3'd6,
    StHalt    = 3'd7
  } state_e;

  localparam logic [3:0] OpR    = 4'b0000;
  localparam logic [3:0] OpAddi = 4'b0100;
  localparam logic [3:0] OpLd   = 4'b1011;
  localparam logic [3:0] OpSt   = 4'b1111;
  localparam logic [3:0] OpBr   = 4'b1000;
  localparam logic [3:0] OpJ    = 4'b0010;
  localparam logic [3:0] OpHalt = 4'b0001;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [15:0]         instr_q, instr_d;
  logic [7:0]          load_data_q, load_data_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                reg_we_q, reg_we_d;
  logic                wb_sel_q, wb_sel_d;
  logic                illegal_q, illegal_d;
  logic                halted_q, halted_d;
  logic                wd_trip;

`ifdef CPU_SEQ_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(WD_CYCLES + 1);

  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
  logic           bus_err_q, bus_err_d;

  // Counts consecutive requesting cycles without an ack.
  always_comb begin
    wd_cnt_d = '0;
    wd_trip  = 1'b0;
    if (mem_req_q && !mem_ack) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
      wd_trip  = (wd_cnt_d == WdW'(WD_CYCLES));
    end
    bus_err_d = bus_err_q | wd_trip;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  logic unused_wd;
  assign unused_wd = ^WD_CYCLES;
  assign wd_trip   = 1'b0;
  assign bus_err   = 1'b0;
`endif

  logic [3:0]        opcode;
  logic [3:0]        opcode_d;
  logic              op_known_d;
  state_e            next_st;
  logic [ADDR_W-1:0] br_off;

  assign opcode   = instr_q[15:12];
  assign opcode_d = instr_d[15:12];
  assign next_st  = run ? StFetchHi : StIdle;
  assign br_off   = {{(ADDR_W-6){instr_q[5]}}, instr_q[5:0]};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    load_data_d = load_data_q;
    case (state_q)
      StIdle:    if (run) state_d = StFetchHi;
      StFetchHi: begin
        if (mem_ack) begin
          instr_d[15:8] = mem_rdata;
          state_d       = StFetchLo;
        end
      end
      StFetchLo: begin
        if (mem_ack) begin
          instr_d[7:0] = mem_rdata;
          pc_d         = pc_q + ADDR_W'(2);
          state_d      = StDecode;
        end
      end
      StDecode:  state_d = (opcode == OpHalt) ? StHalt : StExec;
      StExec: begin
        case (opcode)
          OpR, OpAddi: state_d = StWb;
          OpLd, OpSt:  state_d = StMem;
          OpBr: begin
            if (branch_taken) pc_d = pc_q + br_off;
            state_d = next_st;
          end
          OpJ: begin
            pc_d    = instr_q[ADDR_W-1:0];
            state_d = next_st;
          end
          default:     state_d = next_st;
        endcase
      end
      StMem: begin
        if (mem_ack) begin
          if (opcode == OpLd) begin
            load_data_d = mem_rdata;
            state_d     = StWb;
          end else begin
            state_d = next_st;
          end
        end
      end
      StWb:    state_d = next_st;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
    if (wd_trip) state_d = StHalt;
  end

  always_comb begin
    case (opcode_d)
      OpR, OpAddi, OpLd, OpSt, OpBr, OpJ, OpHalt: op_known_d = 1'b1;
      default:                                    op_known_d = 1'b0;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_comb begin
    mem_req_d   = (state_d == StFetchHi) || (state_d == StFetchLo) || (state_d == StMem);
    mem_we_d    = (state_d == StMem) && (opcode_d == OpSt);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_d != state_q) begin
      case (state_d)
        StFetchHi: mem_addr_d = pc_d;
        StFetchLo: mem_addr_d = pc_d + ADDR_W'(1);
        StMem: begin
          mem_addr_d  = alu_result[ADDR_W-1:0];
          mem_wdata_d = rs2_data;
        end
        default: ;
      endcase
    end
    reg_we_d  = (state_d == StWb);
    wb_sel_d  = (state_d == StWb) && (opcode_d == OpLd);
    illegal_d = (state_d == StDecode) && (state_q != StDecode) && !op_known_d;
    halted_d  = (state_d == StHalt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      load_data_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      wb_sel_q    <= 1'b0;
      illegal_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      load_data_q <= load_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      reg_we_q    <= reg_we_d;
      wb_sel_q    <= wb_sel_d;
      illegal_q   <= illegal_d;
      halted_q    <= halted_d;
    end
  end

  assign state     = state_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign load_data = load_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign reg_we    = reg_we_q;
  assign wb_sel    = wb_sel_q;
  assign illegal   = illegal_q;
  assign halted    = halted_q;

endmodule
